store_aligner: RTL

- Store-path counterpart of the load-path sign extender: takes SB/SH/SW requests from the MEM stage and narrows/places the register operand into the correct byte lanes of a 32-bit data-memory write.
- Generates byte enables and flags misaligned stores.
- A small FIFO decouples the pipeline from data-memory backpressure via a valid/ready handshake on both sides.

---
 rtl/mips_pkg.sv | 11 +
 rtl/store_fifo.sv | 51 +++++
 rtl/store_aligner.sv | 74 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: store-path size encodings and the buffered store entry type.
package mips_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;
endpackage

// File: rtl/store_fifo.sv
// store_fifo: DEPTH-entry buffer of lane-placed stores between the aligner and data memory.
// Ports: clk, rst_n (async active-low); push/din enqueue; pop dequeues head;
// dout = head entry, or the most recently popped entry while empty; full/empty status.
module store_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  store_entry_t din,
    output store_entry_t dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    store_entry_t  mem_q [DEPTH];
    store_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    // While empty, the slot behind the read pointer still holds the last popped
    // entry (writes land at the read pointer), so address/data appear held.
    assign dout  = empty ? mem_q[rd_q - AW'(1)] : mem_q[rd_q];
    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        mem_d   = mem_q;
        if (push_ok) mem_d[wr_q] = din;
        wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/store_aligner.sv
// store_aligner: places SB/SH/SW operands into byte lanes, builds byte enables,
// drops misaligned/reserved stores with a one-cycle misalign pulse, and buffers
// aligned stores toward data memory.
// Ports: req_* valid/ready store request from MEM; mem_* valid/ready word write
// to data memory; misalign pulse with held misalign_addr.
module store_aligner
    import mips_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign,
    output logic [31:0] misalign_addr
);
    logic [1:0]   o;
    logic [3:0]   be_le;
    logic         bad, accept, full, empty;
    logic         misalign_q, misalign_d;
    logic [31:0]  misalign_addr_q, misalign_addr_d;
    store_entry_t ent, head;
    always_comb begin
        o     = req_addr[1:0];
        bad   = req_size == SZ_HALF ? o[0] :
                req_size == SZ_WORD ? o != 2'b00 : req_size != SZ_BYTE;
        be_le = req_size == SZ_BYTE ? 4'b0001 << o :
                req_size == SZ_HALF ? (o[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        ent.addr  = {req_addr[31:2], 2'b00};
        // Replicated data is lane-agnostic, so only the enables depend on endianness.
        ent.wdata = req_size == SZ_BYTE ? {4{req_data[7:0]}} :
                    req_size == SZ_HALF ? {2{req_data[15:0]}} : req_data;
        ent.be    = BIG_ENDIAN ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;
        accept          = req_valid && req_ready;
        misalign_d      = accept && bad;
        misalign_addr_d = misalign_d ? req_addr : misalign_addr_q;
    end
    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && !bad),
        .pop   (mem_valid && mem_ready),
        .din   (ent),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    assign req_ready     = !full;
    assign mem_valid     = !empty;
    assign mem_addr      = head.addr;
    assign mem_wdata     = head.wdata;
    assign mem_be        = empty ? 4'b0000 : head.be;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end
endmodule
